mod12_count_checker: RTL and testbench

Receive-side checker for a modulo-12 count stream, such as the 4-bit count driven by the team's mod-12 counter. It samples a qualified count word each cycle, locks onto a valid ascending modulo sequence, and then verifies every subsequent sample. It flags sequence breaks, out-of-range values and wrap events, and keeps a saturating error tally. It sits at the consuming end of the count bus, in monitors or downstream timing logic.

---
 rtl/mod12_count_checker.sv | 120 ++++++++++++
 tb/tb_mod12_count_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mod12_count_checker.sv
// rtl/mod12_count_checker.sv - receive-side lock/verify checker for a modulo count stream
// Locks onto an ascending modulo sequence, then flags breaks, out-of-range values and wraps.
module mod12_count_checker #(
  parameter int MODULUS  = 12,
  parameter int LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_count,
  input  logic       clear_err,
  output logic       locked,
  output logic       seq_err,
  output logic       range_err,
  output logic       wrap,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] MOD_MAX  = 4'(MODULUS - 1);
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t     state;
  logic [3:0] expected;
  logic [3:0] match_cnt;

  logic       out_of_range;
  logic       hit;
  logic       seq_event;
  logic       err_event;
  logic [3:0] acq_next;

  function automatic logic [3:0] next_val(input logic [3:0] v);
    return (v == MOD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

  // 5-bit compare so MODULUS=16 never flags a 4-bit value
  always_comb begin
    out_of_range = ({1'b0, in_count} >= 5'(MODULUS));
    hit          = (in_count == expected);
    seq_event    = in_valid && !out_of_range && (state == LOCKED) && !hit;
    err_event    = (in_valid && out_of_range) || seq_event;
    acq_next     = match_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      expected  <= 4'd0;
      match_cnt <= 4'd0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
      range_err <= 1'b0;
      wrap      <= 1'b0;
      err_count <= 8'd0;
    end else begin
      seq_err   <= 1'b0;
      range_err <= 1'b0;
      wrap      <= 1'b0;

      // a simultaneous clear and error leaves a tally of one so the event survives
      if (clear_err) begin
        err_count <= err_event ? 8'd1 : 8'd0;
      end else if (err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (in_valid) begin
        if (out_of_range) begin
          range_err <= 1'b1;
          state     <= HUNT;
          match_cnt <= 4'd0;
          locked    <= 1'b0;
        end else begin
          case (state)
            HUNT: begin
              expected  <= next_val(in_count);
              match_cnt <= 4'd1;
              state     <= ACQUIRE;
            end
            ACQUIRE: begin
              expected <= next_val(in_count);
              if (hit) begin
                match_cnt <= acq_next;
                if (acq_next == LOCK_TGT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= 4'd1;
              end
            end
            LOCKED: begin
              expected <= next_val(in_count);
              if (hit) begin
                // expected can only be 0 after a MODULUS-1 sample
                wrap <= (in_count == 4'd0);
              end else begin
                seq_err   <= 1'b1;
                match_cnt <= 4'd1;
                state     <= ACQUIRE;
                locked    <= 1'b0;
              end
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mod12_count_checker.sv
// tb/tb_mod12_count_checker.sv - directed self-checking bench for mod12_count_checker
module tb_mod12_count_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_count = 4'd0;
  logic       clear_err = 1'b0;
  logic       locked, seq_err, range_err, wrap;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  wire [11:0] obs = {locked, seq_err, range_err, wrap, err_count};

  mod12_count_checker #(.MODULUS(12), .LOCK_CNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .clear_err (clear_err),
    .locked    (locked),
    .seq_err   (seq_err),
    .range_err (range_err),
    .wrap      (wrap),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // drive one cycle at negedge, sample 1 time unit after the posedge, then go idle
  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_count  = c;
    clear_err = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", obs, 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock_and_wrap;
    logic [11:0] exp;
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 4'(i % 12), 1'b0);
      exp = {(i >= 2), 1'b0, 1'b0, ((i % 12) == 0) && (i > 0), 8'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lock_wrap[%0d]: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_seq_err;
    logic [3:0]  vals [7] = '{4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [11:0] exps [7] = '{12'h800, 12'h800, 12'h800, 12'h401, 12'h001, 12'h801, 12'h801};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vals[i], 1'b0);
      n_checks++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL seq_err[%0d]: got %b required %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_range_err;
    logic [3:0]  vals [5] = '{4'd13, 4'd13, 4'd0, 4'd1, 4'd2};
    logic [11:0] exps [5] = '{12'h202, 12'h203, 12'h003, 12'h003, 12'h803};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vals[i], 1'b0);
      n_checks++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL range_err[%0d]: got %b required %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_valid_gap;
    step(1'b1, 4'd3, 1'b0);
    n_checks++;
    if (obs !== 12'h803) begin
      n_fail++;
      $display("FAIL gap_pre: got %b required %b", obs, 12'h803);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd15, 1'b0);
      n_checks++;
      if (obs !== 12'h803) begin
        n_fail++;
        $display("FAIL gap_idle[%0d]: got %b required %b", i, obs, 12'h803);
      end
    end
    step(1'b1, 4'd4, 1'b0);
    n_checks++;
    if (obs !== 12'h803) begin
      n_fail++;
      $display("FAIL gap_resume: got %b required %b", obs, 12'h803);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  vals [6] = '{4'd9, 4'd14, 4'd3, 4'd7, 4'd8, 4'd9};
    logic [11:0] exps [6] = '{12'h404, 12'h205, 12'h005, 12'h005, 12'h005, 12'h805};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vals[i], 1'b0);
      n_checks++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b required %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_saturation;
    int exp_err = 5;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'd15, 1'b0);
      if (exp_err < 255) exp_err++;
      n_checks++;
      if (obs !== {4'b0010, 8'(exp_err)}) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %b required %b", i, obs, {4'b0010, 8'(exp_err)});
      end
    end
    step(1'b1, 4'd15, 1'b1);
    n_checks++;
    if (obs !== 12'h201) begin
      n_fail++;
      $display("FAIL clear_with_err: got %b required %b", obs, 12'h201);
    end
    step(1'b0, 4'd15, 1'b1);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL clear_alone: got %b required %b", obs, 12'h000);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0]  vals [3];
    logic [11:0] exps [3];
    for (int i = 0; i < 9; i++) step(1'b1, 4'd12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 1'b0);
    n_checks++;
    if (obs !== 12'h809) begin
      n_fail++;
      $display("FAIL pre_reset: got %b required %b", obs, 12'h809);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", obs, 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    vals = '{4'd4, 4'd5, 4'd6};
    exps = '{12'h000, 12'h000, 12'h800};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 1'b0);
      n_checks++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got %b required %b", i, obs, exps[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_and_wrap();
    test_seq_err();
    test_range_err();
    test_valid_gap();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
